// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and small helpers for the matrix operation engine.
package matrix_pkg;

    localparam int DIM    = 5;
    localparam int ELEM_W = 8;
    localparam int ACC_W  = 20;
    localparam int MAT_W  = DIM * DIM * ELEM_W;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_MUL   = 3'b010;
    localparam logic [2:0] OP_SCALE = 3'b011;
    localparam logic [2:0] OP_TRANS = 3'b100;
    localparam logic [2:0] OP_NEG   = 3'b101;

    localparam logic [1:0] SZ_2 = 2'b00;
    localparam logic [1:0] SZ_3 = 2'b01;
    localparam logic [1:0] SZ_4 = 2'b10;
    localparam logic [1:0] SZ_5 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_DONE
    } state_t;

    function automatic logic signed [ACC_W-1:0] sext(input logic [ELEM_W-1:0] v);
        return {{(ACC_W-ELEM_W){v[ELEM_W-1]}}, v};
    endfunction

    function automatic logic op_valid(input logic [2:0] op);
        return op <= OP_NEG;
    endfunction

endpackage

// File: rtl/matrix_sat.sv
// Clamps a signed accumulator value to the signed element range and flags the clamp.
module matrix_sat
    import matrix_pkg::*;
(
    input  logic signed [ACC_W-1:0] din,
    output logic [ELEM_W-1:0]       dout,
    output logic                    clamp
);
    localparam logic signed [ACC_W-1:0] HI = ACC_W'((2 ** (ELEM_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] LO = -HI - ACC_W'(1);

    always_comb begin
        clamp = 1'b0;
        dout  = din[ELEM_W-1:0];
        if (din > HI) begin
            dout  = HI[ELEM_W-1:0];
            clamp = 1'b1;
        end else if (din < LO) begin
            dout  = LO[ELEM_W-1:0];
            clamp = 1'b1;
        end
    end

endmodule

// File: rtl/matrix_op_engine.sv
// Sequential 5x5 signed matrix engine: element-wise ops one cell per clock,
// multiply as one multiply-accumulate per clock.
module matrix_op_engine
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op_code,
    input  logic [1:0]       matrix_size,
    input  logic [MAT_W-1:0] matrix_a,
    input  logic [MAT_W-1:0] matrix_b,
    output logic [MAT_W-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             op_err
);
    state_t state, state_nxt;

    logic [2:0]              op_r;
    logic [1:0]              size_r;
    logic [MAT_W-1:0]        a_r, b_r;
    logic [2:0]              row, col, k;
    logic signed [ACC_W-1:0] acc;

    logic signed [ELEM_W-1:0] a_m   [DIM][DIM];
    logic signed [ELEM_W-1:0] b_m   [DIM][DIM];
    logic signed [ELEM_W-1:0] res_m [DIM][DIM];

    logic [2:0]              n;
    logic                    in_range, last_cell, cell_end;
    logic signed [ACC_W-1:0] prod, sat_in;
    logic [ELEM_W-1:0]       sat_out;
    logic                    sat_clamp;

    always_comb begin
        for (int unsigned r = 0; r < DIM; r++) begin
            for (int unsigned c = 0; c < DIM; c++) begin
                a_m[r][c] = a_r[(r*DIM+c)*ELEM_W +: ELEM_W];
                b_m[r][c] = b_r[(r*DIM+c)*ELEM_W +: ELEM_W];
                result[(r*DIM+c)*ELEM_W +: ELEM_W] = res_m[r][c];
            end
        end
    end

    always_comb begin
        n         = {1'b0, size_r} + 3'd2;
        in_range  = (row < n) && (col < n);
        last_cell = (row == 3'(DIM - 1)) && (col == 3'(DIM - 1));
        prod      = sext(a_m[row][k]) * sext(b_m[k][col]);
        case (op_r)
            OP_ADD:   sat_in = sext(a_m[row][col]) + sext(b_m[row][col]);
            OP_SUB:   sat_in = sext(a_m[row][col]) - sext(b_m[row][col]);
            OP_MUL:   sat_in = acc + prod;
            OP_SCALE: sat_in = sext(a_m[0][0]) * sext(b_m[row][col]);
            OP_TRANS: sat_in = sext(a_m[col][row]);
            OP_NEG:   sat_in = -sext(a_m[row][col]);
            default:  sat_in = '0;
        endcase
        cell_end = (op_r != OP_MUL) || !in_range || (k == n - 3'd1);
    end

    matrix_sat u_sat (
        .din   (sat_in),
        .dout  (sat_out),
        .clamp (sat_clamp)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = op_valid(op_code) ? ST_COMPUTE : ST_DONE;
            ST_COMPUTE: if (cell_end && last_cell) state_nxt = ST_DONE;
            ST_DONE:    if (done) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r     <= '0;
            size_r   <= '0;
            a_r      <= '0;
            b_r      <= '0;
            row      <= '0;
            col      <= '0;
            k        <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            op_err   <= 1'b0;
            for (int unsigned r = 0; r < DIM; r++)
                for (int unsigned c = 0; c < DIM; c++)
                    res_m[r][c] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_r     <= op_code;
                        size_r   <= matrix_size;
                        a_r      <= matrix_a;
                        b_r      <= matrix_b;
                        row      <= '0;
                        col      <= '0;
                        k        <= '0;
                        acc      <= '0;
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                        op_err   <= 1'b0;
                        for (int unsigned r = 0; r < DIM; r++)
                            for (int unsigned c = 0; c < DIM; c++)
                                res_m[r][c] <= '0;
                    end
                end
                ST_COMPUTE: begin
                    if (cell_end) begin
                        res_m[row][col] <= in_range ? sat_out : '0;
                        if (in_range && sat_clamp) overflow <= 1'b1;
                        acc <= '0;
                        k   <= '0;
                        if (last_cell) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end else if (col == 3'(DIM - 1)) begin
                            col <= '0;
                            row <= row + 3'd1;
                        end else begin
                            col <= col + 3'd1;
                        end
                    end else begin
                        // mid-dot-product: sat_in is the unsaturated running sum acc+prod
                        acc <= sat_in;
                        k   <= k + 3'd1;
                    end
                end
                ST_DONE: begin
                    // an invalid opcode enters DONE with done low and raises it one cycle later
                    if (done) begin
                        done <= 1'b0;
                    end else begin
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        op_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
